// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_rd_pkg
// Brief  : Shared state type and helpers for the FIFO pack reader.
// Rev    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  localparam int unsigned KEEP_MAX = 32;

  function automatic int unsigned cnt_width(input int unsigned ratio);
    return unsigned'($clog2(ratio + 1));
  endfunction

  // (1 << n) - 1, built bitwise so n == KEEP_MAX does not overflow
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned n);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) m[i] = (i < n);
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_outreg.sv
`default_nettype none
// ============================================================================
// Module : fifo_rd_outreg
// Brief  : Valid/ready output holding register for packed beats.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_rd_outreg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic              last_o,
  output logic              free_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [KEEP_W-1:0] keep_q;
  logic              last_q;

  assign free_o  = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

  // ld_i is only raised by the owner while free_o is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (ld_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_pack_reader.sv
`default_nettype none
// ============================================================================
// Module : fifo_pack_reader
// Brief  : Drains a bypass FIFO, packs RATIO words per beat onto a valid/ready
//          port; FIFO_RD_TIMEOUT_EN adds an idle auto-flush.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_pack_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RATIO   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_rdat,
  output logic                   fifo_pop,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]       m_keep,
  output logic                   m_last
);

  localparam int unsigned      C_CNT_W     = cnt_width(RATIO);
  localparam logic [C_CNT_W-1:0] C_LAST_SLOT = C_CNT_W'(RATIO - 1);

  if (RATIO < 2 || RATIO > KEEP_MAX || TIMEOUT < 1) begin : g_bad_params
    $error("fifo_pack_reader: unsupported RATIO or TIMEOUT");
  end

  state_e                      state_q, state_d;
  logic [C_CNT_W-1:0]          cnt_q, cnt_d;
  logic [RATIO-1:0][WIDTH-1:0] acc_q;

  logic                        w_out_free;
  logic                        w_pop;
  logic                        w_timeout;
  logic                        w_flush_req;
  logic                        w_emit;
  logic                        w_last;
  logic                        w_acc_we;
  logic [C_CNT_W-1:0]          w_n;
  logic [WIDTH*RATIO-1:0]      w_beat;
  logic [RATIO-1:0]            w_keep;

  assign w_pop       = ~rst & ~fifo_empty & ((cnt_q < C_LAST_SLOT) | w_out_free);
  assign fifo_pop    = w_pop;
  assign w_flush_req = flush | w_timeout;
  assign w_n         = cnt_q + C_CNT_W'(w_pop);
  assign w_keep      = RATIO'(keep_mask(32'(w_n)));
  assign w_last      = (state_q == S_FLUSH) | w_flush_req;
  // A full beat in S_FILL always has out_free, since popping the last slot requires it
  assign w_emit      = ((state_q == S_FILL) & w_pop & (cnt_q == C_LAST_SLOT)) |
                       ((state_q == S_FLUSH) & w_out_free);

  always_comb begin
    w_beat = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (C_CNT_W'(i) < cnt_q) begin
        w_beat[i*WIDTH +: WIDTH] = acc_q[i];
      end else if ((C_CNT_W'(i) == cnt_q) && w_pop) begin
        w_beat[i*WIDTH +: WIDTH] = fifo_rdat;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_acc_we = 1'b0;
    if (w_emit) begin
      state_d = S_FILL;
      cnt_d   = '0;
    end else begin
      if (w_pop) begin
        w_acc_we = 1'b1;
        cnt_d    = cnt_q + C_CNT_W'(1);
      end
      if ((state_q == S_FILL) && w_flush_req && ((cnt_q != '0) || w_pop)) begin
        state_d = S_FLUSH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (w_acc_we && (cnt_q == C_CNT_W'(i))) acc_q[i] <= fifo_rdat;
      end
    end
  end

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int unsigned C_IDLE_W = unsigned'($clog2(TIMEOUT + 1));

  logic [C_IDLE_W-1:0] idle_q;

  assign w_timeout = (state_q == S_FILL) & (cnt_q != '0) & ~w_pop &
                     (idle_q == C_IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else if (w_pop || w_emit || (state_q != S_FILL) || (cnt_q == '0) || w_timeout) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + C_IDLE_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  fifo_rd_outreg #(
    .DATA_W (WIDTH * RATIO),
    .KEEP_W (RATIO)
  ) u_outreg (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (w_emit),
    .data_i  (w_beat),
    .keep_i  (w_keep),
    .last_i  (w_last),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data),
    .keep_o  (m_keep),
    .last_o  (m_last),
    .free_o  (w_out_free)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_pack_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_pack_reader
// Brief  : Directed self-checking bench for fifo_pack_reader (WIDTH=8, RATIO=4).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fifo_pack_reader;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned RATIO   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   fifo_empty;
  logic [WIDTH-1:0]       fifo_rdat;
  logic                   fifo_pop;
  logic                   flush;
  logic                   m_valid;
  logic                   m_ready;
  logic [WIDTH*RATIO-1:0] m_data;
  logic [RATIO-1:0]       m_keep;
  logic                   m_last;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops   = 0;

  logic [WIDTH-1:0]       fq[$];
  logic [WIDTH*RATIO-1:0] log_data[$];
  logic [RATIO-1:0]       log_keep[$];
  logic                   log_last[$];
  int                     log_cyc[$];

  always #5 clk = ~clk;

  fifo_pack_reader #(
    .WIDTH   (WIDTH),
    .RATIO   (RATIO),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdat  (fifo_rdat),
    .fifo_pop   (fifo_pop),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last)
  );

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_rdat  = fifo_empty ? '0 : fq[0];
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fq.push_back(w);
    refresh();
  endtask

  task automatic clear_log();
    log_data.delete();
    log_keep.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  // One clock: sample at the falling edge, then retire the popped head after the rising edge
  task automatic tick();
    logic pop_s;
    @(negedge clk);
    pop_s = fifo_pop;
    if (m_valid && m_ready) begin
      log_data.push_back(m_data);
      log_keep.push_back(m_keep);
      log_last.push_back(m_last);
      log_cyc.push_back(cyc);
    end
    if (pop_s) pops++;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_s && fq.size() != 0) fq.delete(0);
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    push(8'h99);
    pops = 0;
    run(2);
    checks++;
    if (fifo_pop !== 1'b0) begin
      errors++;
      $display("FAIL reset_pop got %b exp 0", fifo_pop);
    end
    checks++;
    if ({m_valid, m_data, m_keep, m_last} !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h k=%h l=%b exp all 0", m_valid, m_data, m_keep, m_last);
    end
    checks++;
    if (pops !== 0) begin
      errors++;
      $display("FAIL reset_pop_count got %0d exp 0", pops);
    end
    fq.delete();
    refresh();
    rst = 1'b0;
    run(2);
    clear_log();
  endtask

  task automatic test_full_beat();
    m_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    run(8);
    checks++;
    if (log_data.size() != 1) begin
      errors++;
      $display("FAIL full_beat_count got %0d exp 1", log_data.size());
    end
    if (log_data.size() >= 1) begin
      checks++;
      if ({log_data[0], log_keep[0], log_last[0]} !== {32'h04030201, 4'hF, 1'b0}) begin
        errors++;
        $display("FAIL full_beat_data got d=%h k=%h l=%b exp d=04030201 k=f l=0",
                 log_data[0], log_keep[0], log_last[0]);
      end
    end
    clear_log();
  endtask

  task automatic test_flush_partial();
    push(8'hAA); push(8'hBB);
    run(2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run(4);
    checks++;
    if (log_data.size() != 1) begin
      errors++;
      $display("FAIL flush_partial_count got %0d exp 1", log_data.size());
    end
    if (log_data.size() >= 1) begin
      checks++;
      if ({log_data[0], log_keep[0], log_last[0]} !== {32'h0000BBAA, 4'h3, 1'b1}) begin
        errors++;
        $display("FAIL flush_partial_data got d=%h k=%h l=%b exp d=0000bbaa k=3 l=1",
                 log_data[0], log_keep[0], log_last[0]);
      end
    end
    clear_log();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run(4);
    checks++;
    if (log_data.size() != 0) begin
      errors++;
      $display("FAIL flush_empty_count got %0d exp 0", log_data.size());
    end
    clear_log();
  endtask

  task automatic test_backpressure();
    logic [WIDTH*RATIO-1:0] d_mid;
    m_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    run(6);
    d_mid = m_data;
    run(6);
    checks++;
    if (pops !== 7) begin
      errors++;
      $display("FAIL bp_pop_count got %0d exp 7", pops);
    end
    checks++;
    if ({m_valid, m_data, m_keep, m_last} !== {1'b1, 32'h13121110, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL bp_held_beat got v=%b d=%h k=%h l=%b exp v=1 d=13121110 k=f l=0",
               m_valid, m_data, m_keep, m_last);
    end
    checks++;
    if (d_mid !== 32'h13121110) begin
      errors++;
      $display("FAIL bp_mid_data got %h exp 13121110", d_mid);
    end
    checks++;
    if (fifo_pop !== 1'b0 || fq.size() != 1) begin
      errors++;
      $display("FAIL bp_stall got pop=%b left=%0d exp pop=0 left=1", fifo_pop, fq.size());
    end
    m_ready = 1'b1;
    run(8);
    checks++;
    if (log_data.size() != 2) begin
      errors++;
      $display("FAIL bp_release_count got %0d exp 2", log_data.size());
    end
    if (log_data.size() >= 2) begin
      checks++;
      if ({log_data[0], log_data[1]} !== {32'h13121110, 32'h17161514}) begin
        errors++;
        $display("FAIL bp_release_data got %h %h exp 13121110 17161514", log_data[0], log_data[1]);
      end
    end
    clear_log();
  endtask

  task automatic test_flush_on_last_pop();
    for (int i = 0; i < 6; i++) push(8'h21 + 8'(i));
    run(3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run(4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run(4);
    checks++;
    if (log_data.size() != 2) begin
      errors++;
      $display("FAIL flush_last_count got %0d exp 2", log_data.size());
    end
    if (log_data.size() >= 2) begin
      checks++;
      if ({log_data[0], log_keep[0], log_last[0]} !== {32'h24232221, 4'hF, 1'b1}) begin
        errors++;
        $display("FAIL flush_last_beat0 got d=%h k=%h l=%b exp d=24232221 k=f l=1",
                 log_data[0], log_keep[0], log_last[0]);
      end
      checks++;
      if ({log_data[1], log_keep[1], log_last[1]} !== {32'h00002625, 4'h3, 1'b1}) begin
        errors++;
        $display("FAIL flush_last_beat1 got d=%h k=%h l=%b exp d=00002625 k=3 l=1",
                 log_data[1], log_keep[1], log_last[1]);
      end
    end
    clear_log();
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [WIDTH*RATIO-1:0] exp_d;
    m_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 16; i++) push(8'(i));
    t0 = cyc;
    run(16);
    checks++;
    if (pops !== 16) begin
      errors++;
      $display("FAIL b2b_pops got %0d exp 16", pops);
    end
    run(4);
    checks++;
    if (log_data.size() != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 4", log_data.size());
    end
    for (int b = 0; b < 4 && b < log_data.size(); b++) begin
      exp_d = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
      checks++;
      if ({log_data[b], log_keep[b], log_last[b]} !== {exp_d, 4'hF, 1'b0} ||
          log_cyc[b] != t0 + 4*(b+1)) begin
        errors++;
        $display("FAIL b2b_beat%0d got d=%h k=%h l=%b t=%0d exp d=%h k=f l=0 t=%0d",
                 b, log_data[b], log_keep[b], log_last[b], log_cyc[b] - t0, exp_d, 4*(b+1));
      end
    end
    clear_log();
  endtask

  task automatic test_timeout();
    int p;
    m_ready = 1'b1;
    push(8'h5A);
    p = cyc;
    tick();
`ifdef FIFO_RD_TIMEOUT_EN
    run(22);
    checks++;
    if (log_data.size() != 1) begin
      errors++;
      $display("FAIL timeout_count got %0d exp 1", log_data.size());
    end
    if (log_data.size() >= 1) begin
      checks++;
      if ({log_data[0], log_keep[0], log_last[0]} !== {32'h0000005A, 4'h1, 1'b1} ||
          log_cyc[0] != p + 18) begin
        errors++;
        $display("FAIL timeout_beat got d=%h k=%h l=%b t=%0d exp d=0000005a k=1 l=1 t=18",
                 log_data[0], log_keep[0], log_last[0], log_cyc[0] - p);
      end
    end
`else
    run(30);
    checks++;
    if (log_data.size() != 0) begin
      errors++;
      $display("FAIL no_timeout_count got %0d exp 0 (p=%0d)", log_data.size(), p);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run(4);
    checks++;
    if (log_data.size() != 1) begin
      errors++;
      $display("FAIL no_timeout_flush_count got %0d exp 1", log_data.size());
    end
    if (log_data.size() >= 1) begin
      checks++;
      if ({log_data[0], log_keep[0], log_last[0]} !== {32'h0000005A, 4'h1, 1'b1}) begin
        errors++;
        $display("FAIL no_timeout_flush_beat got d=%h k=%h l=%b exp d=0000005a k=1 l=1",
                 log_data[0], log_keep[0], log_last[0]);
      end
    end
`endif
    clear_log();
  endtask

  task automatic test_reset_mid_beat();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h41 + 8'(i));
    run(6);
    push(8'h46);
    rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_data, m_keep, m_last} !== 38'h0 || fifo_pop !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs got v=%b d=%h k=%h l=%b pop=%b exp all 0",
               m_valid, m_data, m_keep, m_last, fifo_pop);
    end
    tick();
    fq.delete();
    refresh();
    rst = 1'b0;
    m_ready = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run(4);
    checks++;
    if (log_data.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_no_beat got %0d exp 0", log_data.size());
    end
    clear_log();
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    m_ready    = 1'b1;
    fifo_empty = 1'b1;
    fifo_rdat  = '0;
    test_reset();
    test_full_beat();
    test_flush_partial();
    test_backpressure();
    test_flush_on_last_pop();
    test_back_to_back();
    test_timeout();
    test_reset_mid_beat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
